ex_stage_muldiv: RTL and testbench
==================================

EX_STAGE_MULDIV -- requirements
Module: ex_stage_muldiv

Interface
REQ-001 Parameter XLEN, default 32: datapath width; legal values 32 or 64.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 validE  in  1  instruction in EX is valid.
REQ-005 FlushE  in  1  kill instruction in EX.
REQ-006 RD1E, RD2E, PCE, ImmExtE  in  XLEN each  register operands, PC, immediate.
REQ-007 ResultW, ALUResultM  in  XLEN each  forwarding sources.
REQ-008 ForwardAE, ForwardBE  in  2 each  forward select: 00 RDx, 01 ResultW, 10 ALUResultM.
REQ-009 SrcAsrcE, ALUSrcE  in  1 each  SrcA=PC / SrcB=ImmExt when set.
REQ-010 ALUControlE  in  4  ALU op code.
REQ-011 MulDivE  in  1  instruction is RV M-extension.
REQ-012 funct3E  in  3  M op: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (000..111).
REQ-013 BranchE, JumpE, JumpRegE  in  1 each  branch/jump controls.
REQ-014 ALUResultE  out  XLEN  execute result.
REQ-015 WriteDataE  out  XLEN  forwarded RS2 value.
REQ-016 PCSrcE  out  1  redirect; PCTargetE  out  XLEN  target.
REQ-017 StallEX  out  1  hold F/D/E, bubble into M.

Function
REQ-018 Non-M path SHALL be combinational: forwarding muxes, SrcA/SrcB muxes, ALU, branch compare on forwarded RS1/RS2; PCSrcE = (BranchE & taken) | JumpE; PCTargetE = (JumpRegE ? SrcA : PCE) + ImmExtE.
REQ-019 M-unit FSM states SHALL be IDLE, BUSY, DONE; reset state IDLE.
REQ-020 Issue: validE & MulDivE & ~FlushE in IDLE SHALL capture forwarded operands and funct3 into registers; later forwarding changes SHALL NOT affect the result.
REQ-021 StallEX SHALL equal validE & MulDivE & ~FlushE & (state != DONE), combinationally.
REQ-022 IDLE->BUSY on issue for normal divide and iterative multiply; iteration counter cleared to 0.
REQ-023 BUSY: one quotient/product bit per cycle; after exactly XLEN BUSY cycles SHALL go DONE (counter XLEN-1 -> DONE, no wrap).
REQ-024 DONE SHALL last exactly one cycle, drive ALUResultE from result register, StallEX=0, then return IDLE.
REQ-025 Divide-by-zero: quotient all ones, remainder = dividend; signed overflow (-2^(XLEN-1) / -1): quotient = dividend, remainder 0; both SHALL go IDLE->DONE directly (one stall cycle).
REQ-026 Signed ops SHALL operate on magnitudes and correct sign at DONE; remainder sign follows dividend; MULH* return upper XLEN bits of 2*XLEN product, MUL lower XLEN.
REQ-027 FlushE in BUSY or DONE SHALL drop StallEX same cycle and force IDLE next edge; no result emitted.
REQ-028 validE=0 with MulDivE=1 SHALL NOT issue.

Reset
REQ-029 reset SHALL immediately force state IDLE, counter 0, operand/result registers 0; StallEX therefore 0 when validE=0.
REQ-030 reset mid-BUSY SHALL abandon the operation; after release next M instruction issues normally.

Configuration
REQ-031 Macro EX_STAGE_FAST_MUL_EN: defined -> MUL* use a single-cycle multiplier, IDLE->DONE directly (one stall cycle); undefined -> MUL* iterate XLEN BUSY cycles like divide. Divide behaviour identical both ways.

Verification
REQ-032 DIV 100 / -7 (XLEN=32) -> StallEX high 33 cycles, DONE cycle ALUResultE=0xFFFFFFF2; REM same operands -> 0x00000002.
REQ-033 DIVU 0x1234/0 -> 0xFFFFFFFF; REM 5/0 -> 5; StallEX high one cycle.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; one stall cycle.
REQ-035 MULH 0xFFFFFFFF*0xFFFFFFFF -> 0; MULHU -> 0xFFFFFFFE; MUL -> 1; stall 1 cycle with EX_STAGE_FAST_MUL_EN, 33 cycles without.
REQ-036 FlushE at BUSY cycle 10 -> StallEX low same cycle, IDLE next edge; following ADD 3+4 -> ALUResultE=7 with no stall.
REQ-037 reset pulse at BUSY cycle 5 -> state IDLE, StallEX 0 immediately; next DIVU 9/3 -> 3 after 33 stall cycles.

Source files
------------

// File: rtl/ex_stage_muldiv_if.sv
// rtl/ex_stage_muldiv_if.sv - execute-stage operand/control bundle and results
//
// Purpose : groups every non-clock signal of ex_stage_muldiv.
// Ports   : master = decode/hazard side (drives operands and controls,
//           reads results); slave = execute stage.
//           validE, FlushE, RD1E, RD2E, PCE, ImmExtE, ResultW, ALUResultM,
//           ForwardAE, ForwardBE, SrcAsrcE, ALUSrcE, ALUControlE, MulDivE,
//           funct3E, BranchE, JumpE, JumpRegE -> execute stage
//           ALUResultE, WriteDataE, PCSrcE, PCTargetE, StallEX <- execute stage
interface ex_stage_muldiv_if #(
   parameter int XLEN = 32
);
   logic            validE;
   logic            FlushE;
   logic [XLEN-1:0] RD1E;
   logic [XLEN-1:0] RD2E;
   logic [XLEN-1:0] PCE;
   logic [XLEN-1:0] ImmExtE;
   logic [XLEN-1:0] ResultW;
   logic [XLEN-1:0] ALUResultM;
   logic [1:0]      ForwardAE;
   logic [1:0]      ForwardBE;
   logic            SrcAsrcE;
   logic            ALUSrcE;
   logic [3:0]      ALUControlE;
   logic            MulDivE;
   logic [2:0]      funct3E;
   logic            BranchE;
   logic            JumpE;
   logic            JumpRegE;
   logic [XLEN-1:0] ALUResultE;
   logic [XLEN-1:0] WriteDataE;
   logic            PCSrcE;
   logic [XLEN-1:0] PCTargetE;
   logic            StallEX;

   modport master (
      output validE, FlushE, RD1E, RD2E, PCE, ImmExtE, ResultW, ALUResultM,
             ForwardAE, ForwardBE, SrcAsrcE, ALUSrcE, ALUControlE, MulDivE,
             funct3E, BranchE, JumpE, JumpRegE,
      input  ALUResultE, WriteDataE, PCSrcE, PCTargetE, StallEX
   );

   modport slave (
      input  validE, FlushE, RD1E, RD2E, PCE, ImmExtE, ResultW, ALUResultM,
             ForwardAE, ForwardBE, SrcAsrcE, ALUSrcE, ALUControlE, MulDivE,
             funct3E, BranchE, JumpE, JumpRegE,
      output ALUResultE, WriteDataE, PCSrcE, PCTargetE, StallEX
   );
endinterface

// File: rtl/ex_stage_muldiv.sv
// rtl/ex_stage_muldiv.sv - RISC-V execute stage with multi-cycle M-extension unit
//
// Purpose : combinational forwarding/ALU/branch path plus an IDLE/BUSY/DONE
//           multiply/divide unit that stalls the front of the pipe.
// Ports   : clk   - clock, rising edge
//           reset - asynchronous, active-high
//           bus   - ex_stage_muldiv_if.slave (operands, controls, results)
// Config  : EX_STAGE_FAST_MUL_EN - when defined, MUL/MULH/MULHSU/MULHU use a
//           single-cycle multiplier instead of the bit-serial one.
// ALU ops : 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll,
//           8 srl, 9 sra, 10 pass SrcB.
// Branch  : funct3E selects beq/bne/blt/bge/bltu/bgeu.
module ex_stage_muldiv #(
   parameter int XLEN = 32
) (
   input  logic             clk,
   input  logic             reset,
   ex_stage_muldiv_if.slave bus
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t              state;
   logic [XLEN-1:0]     fwd_a, fwd_b, src_a, src_b, alu_out;
   logic                taken;

   // ---------------- forwarding and operand selection ----------------
   always_comb begin
      case (bus.ForwardAE)
         2'b01:   fwd_a = bus.ResultW;
         2'b10:   fwd_a = bus.ALUResultM;
         default: fwd_a = bus.RD1E;
      endcase
      case (bus.ForwardBE)
         2'b01:   fwd_b = bus.ResultW;
         2'b10:   fwd_b = bus.ALUResultM;
         default: fwd_b = bus.RD2E;
      endcase
   end

   assign src_a = bus.SrcAsrcE ? bus.PCE     : fwd_a;
   assign src_b = bus.ALUSrcE  ? bus.ImmExtE : fwd_b;

   // ---------------- ALU ----------------
   always_comb begin
      alu_out = '0;
      case (bus.ALUControlE)
         4'd0:    alu_out = src_a + src_b;
         4'd1:    alu_out = src_a - src_b;
         4'd2:    alu_out = src_a & src_b;
         4'd3:    alu_out = src_a | src_b;
         4'd4:    alu_out = src_a ^ src_b;
         4'd5:    alu_out = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
         4'd6:    alu_out = {{(XLEN-1){1'b0}}, src_a < src_b};
         4'd7:    alu_out = src_a << src_b[CW-1:0];
         4'd8:    alu_out = src_a >> src_b[CW-1:0];
         4'd9:    alu_out = $signed(src_a) >>> src_b[CW-1:0];
         4'd10:   alu_out = src_b;
         default: alu_out = '0;
      endcase
   end

   // ---------------- branch / jump ----------------
   always_comb begin
      taken = 1'b0;
      case (bus.funct3E)
         3'b000:  taken = (fwd_a == fwd_b);
         3'b001:  taken = (fwd_a != fwd_b);
         3'b100:  taken = ($signed(fwd_a) <  $signed(fwd_b));
         3'b101:  taken = ($signed(fwd_a) >= $signed(fwd_b));
         3'b110:  taken = (fwd_a <  fwd_b);
         3'b111:  taken = (fwd_a >= fwd_b);
         default: taken = 1'b0;
      endcase
   end

   assign bus.PCSrcE     = (bus.BranchE & taken) | bus.JumpE;
   assign bus.PCTargetE  = (bus.JumpRegE ? src_a : bus.PCE) + bus.ImmExtE;
   assign bus.WriteDataE = fwd_b;

   // ---------------- M-unit issue decode ----------------
   logic                m_req, issue, is_div, sgn_a, sgn_b, neg_a, neg_b;
   logic                div_zero, div_ovf;
   logic [XLEN-1:0]     mag_a, mag_b;
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   assign m_req  = bus.validE & bus.MulDivE & ~bus.FlushE;
   assign issue  = m_req & (state == S_IDLE);
   assign bus.StallEX = m_req & (state != S_DONE);

   assign is_div = bus.funct3E[2];
   // DIV/REM signed on both sides; MULH signed both, MULHSU signed rs1 only.
   // MUL is treated unsigned: the low half is sign-independent.
   assign sgn_a  = is_div ? ~bus.funct3E[0]
                          : (bus.funct3E[1:0] == 2'b01) | (bus.funct3E[1:0] == 2'b10);
   assign sgn_b  = is_div ? ~bus.funct3E[0] : (bus.funct3E[1:0] == 2'b01);
   assign neg_a  = sgn_a & fwd_a[XLEN-1];
   assign neg_b  = sgn_b & fwd_b[XLEN-1];
   assign mag_a  = neg_a ? -fwd_a : fwd_a;
   assign mag_b  = neg_b ? -fwd_b : fwd_b;

   assign div_zero = is_div & (fwd_b == '0);
   assign div_ovf  = is_div & ~bus.funct3E[0] & (fwd_a == MIN_INT) & (fwd_b == '1);

`ifdef EX_STAGE_FAST_MUL_EN
   logic [2*XLEN-1:0]   fprod, fprod_s;
   logic [XLEN-1:0]     fast_res;
   assign fprod    = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
   assign fprod_s  = (neg_a ^ neg_b) ? -fprod : fprod;
   assign fast_res = (bus.funct3E[1:0] == 2'b00) ? fprod_s[XLEN-1:0]
                                                 : fprod_s[2*XLEN-1:XLEN];
`endif

   // ---------------- M-unit datapath registers ----------------
   // work_hi/work_lo hold remainder/quotient for divide and the running
   // upper/lower product halves for multiply.
   logic [2:0]          f3_r;
   logic                neg_p_r, neg_r_r;
   logic [XLEN-1:0]     opb_r, work_hi, work_lo, res_r;
   logic [CW-1:0]       cnt;

   logic [XLEN:0]       rs, diff, sum;
   logic [XLEN-1:0]     hi_n, lo_n, q_fix, r_fix, fin;
   logic [2*XLEN-1:0]   prod, prod_s;

   always_comb begin
      rs   = {work_hi, work_lo[XLEN-1]};
      diff = rs - {1'b0, opb_r};
      sum  = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opb_r} : '0);
      hi_n = '0;
      lo_n = '0;
      if (f3_r[2]) begin
         // Restoring division: a borrow out of diff means the trial
         // subtraction failed, so keep the shifted remainder.
         if (diff[XLEN]) begin
            hi_n = rs[XLEN-1:0];
            lo_n = {work_lo[XLEN-2:0], 1'b0};
         end else begin
            hi_n = diff[XLEN-1:0];
            lo_n = {work_lo[XLEN-2:0], 1'b1};
         end
      end else begin
         // Shift-add multiply: low half shifts out multiplier bits and
         // shifts in product bits.
         hi_n = sum[XLEN:1];
         lo_n = {sum[0], work_lo[XLEN-1:1]};
      end

      q_fix  = neg_p_r ? -lo_n : lo_n;
      r_fix  = neg_r_r ? -hi_n : hi_n;
      prod   = {hi_n, lo_n};
      prod_s = neg_p_r ? -prod : prod;

      if (f3_r[2])
         fin = f3_r[1] ? r_fix : q_fix;
      else if (f3_r[1:0] == 2'b00)
         fin = prod_s[XLEN-1:0];
      else
         fin = prod_s[2*XLEN-1:XLEN];
   end

   // ---------------- M-unit FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         f3_r    <= '0;
         neg_p_r <= 1'b0;
         neg_r_r <= 1'b0;
         opb_r   <= '0;
         work_hi <= '0;
         work_lo <= '0;
         res_r   <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (issue) begin
                  f3_r    <= bus.funct3E;
                  neg_p_r <= neg_a ^ neg_b;
                  neg_r_r <= neg_a;
                  opb_r   <= mag_b;
                  work_hi <= '0;
                  work_lo <= mag_a;
                  cnt     <= '0;
                  if (div_zero) begin
                     res_r <= bus.funct3E[1] ? fwd_a : '1;
                     state <= S_DONE;
                  end else if (div_ovf) begin
                     res_r <= bus.funct3E[1] ? '0 : fwd_a;
                     state <= S_DONE;
                  end
`ifdef EX_STAGE_FAST_MUL_EN
                  else if (!is_div) begin
                     res_r <= fast_res;
                     state <= S_DONE;
                  end
`endif
                  else begin
                     state <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               if (bus.FlushE) begin
                  state <= S_IDLE;
               end else begin
                  work_hi <= hi_n;
                  work_lo <= lo_n;
                  if (cnt == CW'(XLEN-1)) begin
                     res_r <= fin;
                     state <= S_DONE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // A flushed DONE cycle shows the plain ALU value: the M result is dropped.
   assign bus.ALUResultE = ((state == S_DONE) && !bus.FlushE) ? res_r : alu_out;

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// tb/tb_ex_stage_muldiv.sv - self-checking bench for ex_stage_muldiv
module tb_ex_stage_muldiv;
   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ex_stage_muldiv_if #(.XLEN(XLEN)) bus ();
   ex_stage_muldiv #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_ref(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb;
      logic [63:0] t;
      logic ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      t   = '0;
      case (f3)
         3'd0: begin t = sa * sb; return t[31:0]; end
         3'd1: begin t = sa * sb; return t[63:32]; end
         3'd2: begin t = sa * longint'({32'b0, b}); return t[63:32]; end
         3'd3: begin t = {32'b0, a} * {32'b0, b}; return t[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            t = sa / sb; return t[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            t = sa % sb; return t[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int m_stalls(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
      if (f3[2]) begin
         if (b == 0) return 1;
         if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
         return XLEN + 1;
      end
`ifdef EX_STAGE_FAST_MUL_EN
      return 1;
`else
      return XLEN + 1;
`endif
   endfunction

   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'd6:  return (a < b) ? 32'd1 : 32'd0;
         4'd7:  return a << sh;
         4'd8:  return a >> sh;
         4'd9:  return $signed(a) >>> sh;
         4'd10: return b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic br_ref(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
      case (f3)
         3'b000: return a == b;
         3'b001: return a != b;
         3'b100: return int'(a) < int'(b);
         3'b101: return int'(a) >= int'(b);
         3'b110: return a < b;
         3'b111: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic scramble();
      bus.RD1E       = $urandom;
      bus.RD2E       = $urandom;
      bus.ResultW    = $urandom;
      bus.ALUResultM = $urandom;
   endtask

   // ---------------- M operation: issue, count stalls, check result ----------------
   task automatic m_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b);
      int stalls;
      logic [1:0] fa, fb;
      fa = 2'($urandom_range(0, 2));
      fb = 2'($urandom_range(0, 2));
      if (fb == fa && fa != 2'd0) fb = 2'd0;
      @(negedge clk);
      scramble();
      case (fa)
         2'd1:    bus.ResultW    = a;
         2'd2:    bus.ALUResultM = a;
         default: bus.RD1E       = a;
      endcase
      case (fb)
         2'd1:    bus.ResultW    = b;
         2'd2:    bus.ALUResultM = b;
         default: bus.RD2E       = b;
      endcase
      bus.ForwardAE = fa;
      bus.ForwardBE = fb;
      bus.SrcAsrcE  = 1'b0;
      bus.ALUSrcE   = 1'b0;
      bus.funct3E   = f3;
      bus.FlushE    = 1'b0;
      bus.validE    = 1'b1;
      bus.MulDivE   = 1'b1;
      #1;
      stalls = 0;
      while (bus.StallEX === 1'b1 && stalls < 200) begin
         stalls++;
         @(negedge clk);
         scramble();
         #1;
      end
      chk($sformatf("%s stalls", tag), 64'(stalls), 64'(m_stalls(f3, a, b)));
      chk($sformatf("%s result", tag), 64'(bus.ALUResultE), 64'(m_ref(f3, a, b)));
      bus.validE  = 1'b0;
      bus.MulDivE = 1'b0;
   endtask

   // ---------------- random non-M vector ----------------
   task automatic alu_vec(input int idx);
      logic [2:0] br_f3 [6];
      logic [31:0] fa, fb, sa, sb, tgt;
      br_f3 = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
      @(negedge clk);
      scramble();
      bus.PCE     = $urandom;
      bus.ImmExtE = $urandom;
      if ($urandom_range(0, 2) == 0) begin
         bus.RD2E       = bus.RD1E;
         bus.ALUResultM = bus.ResultW;
      end
      bus.ForwardAE   = 2'($urandom_range(0, 2));
      bus.ForwardBE   = 2'($urandom_range(0, 2));
      bus.SrcAsrcE    = 1'($urandom_range(0, 1));
      bus.ALUSrcE     = 1'($urandom_range(0, 1));
      bus.ALUControlE = 4'($urandom_range(0, 10));
      bus.funct3E     = br_f3[$urandom_range(0, 5)];
      bus.BranchE     = 1'($urandom_range(0, 1));
      bus.JumpE       = ($urandom_range(0, 3) == 0);
      bus.JumpRegE    = 1'($urandom_range(0, 1));
      bus.validE      = 1'b1;
      bus.MulDivE     = 1'b0;
      bus.FlushE      = 1'b0;
      fa  = (bus.ForwardAE == 2'd1) ? bus.ResultW : (bus.ForwardAE == 2'd2) ? bus.ALUResultM : bus.RD1E;
      fb  = (bus.ForwardBE == 2'd1) ? bus.ResultW : (bus.ForwardBE == 2'd2) ? bus.ALUResultM : bus.RD2E;
      sa  = bus.SrcAsrcE ? bus.PCE : fa;
      sb  = bus.ALUSrcE ? bus.ImmExtE : fb;
      tgt = (bus.JumpRegE ? sa : bus.PCE) + bus.ImmExtE;
      #1;
      chk($sformatf("alu%0d result", idx), 64'(bus.ALUResultE), 64'(alu_ref(bus.ALUControlE, sa, sb)));
      chk($sformatf("alu%0d wdata", idx), 64'(bus.WriteDataE), 64'(fb));
      chk($sformatf("alu%0d pcsrc", idx), 64'(bus.PCSrcE),
          64'((bus.BranchE & br_ref(bus.funct3E, fa, fb)) | bus.JumpE));
      chk($sformatf("alu%0d target", idx), 64'(bus.PCTargetE), 64'(tgt));
      chk($sformatf("alu%0d stall", idx), 64'(bus.StallEX), 64'd0);
      bus.validE = 1'b0;
   endtask

   function automatic logic [31:0] pick_op();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      reset           = 1'b1;
      bus.validE      = 1'b0;
      bus.FlushE      = 1'b0;
      bus.RD1E        = '0;
      bus.RD2E        = '0;
      bus.PCE         = '0;
      bus.ImmExtE     = '0;
      bus.ResultW     = '0;
      bus.ALUResultM  = '0;
      bus.ForwardAE   = '0;
      bus.ForwardBE   = '0;
      bus.SrcAsrcE    = 1'b0;
      bus.ALUSrcE     = 1'b0;
      bus.ALUControlE = '0;
      bus.MulDivE     = 1'b0;
      bus.funct3E     = '0;
      bus.BranchE     = 1'b0;
      bus.JumpE       = 1'b0;
      bus.JumpRegE    = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      chk("reset stall", 64'(bus.StallEX), 64'd0);
      chk("reset result", 64'(bus.ALUResultE), 64'd0);
      chk("reset pcsrc", 64'(bus.PCSrcE), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // directed corner cases
      m_op("div 100/-7",      3'b100, 32'd100, 32'hFFFF_FFF9);
      m_op("rem 100/-7",      3'b110, 32'd100, 32'hFFFF_FFF9);
      m_op("divu 0x1234/0",   3'b101, 32'h1234, 32'h0);
      m_op("rem 5/0",         3'b110, 32'd5, 32'h0);
      m_op("div ovf",         3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
      m_op("rem ovf",         3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
      m_op("mulh -1*-1",      3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      m_op("mulhu max*max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      m_op("mul -1*-1",       3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      m_op("mulhsu -2*max",   3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFF);

      // MulDivE without validE must not start the unit
      @(negedge clk);
      bus.validE  = 1'b0;
      bus.MulDivE = 1'b1;
      bus.funct3E = 3'b101;
      bus.RD1E    = 32'd77;
      bus.RD2E    = 32'd7;
      #1;
      chk("novalid stall", 64'(bus.StallEX), 64'd0);
      repeat (3) @(negedge clk);
      bus.MulDivE = 1'b0;
      m_op("divu after novalid", 3'b101, 32'd77, 32'd7);

      // flush in the middle of a divide
      @(negedge clk);
      bus.ForwardAE = 2'd0;
      bus.ForwardBE = 2'd0;
      bus.RD1E      = 32'd1000;
      bus.RD2E      = 32'd7;
      bus.funct3E   = 3'b100;
      bus.validE    = 1'b1;
      bus.MulDivE   = 1'b1;
      #1;
      chk("flush issue stall", 64'(bus.StallEX), 64'd1);
      repeat (10) @(negedge clk);
      bus.FlushE = 1'b1;
      #1;
      chk("flush drops stall", 64'(bus.StallEX), 64'd0);
      @(negedge clk);
      bus.FlushE      = 1'b0;
      bus.MulDivE     = 1'b0;
      bus.ALUControlE = 4'd0;
      bus.SrcAsrcE    = 1'b0;
      bus.ALUSrcE     = 1'b0;
      bus.RD1E        = 32'd3;
      bus.RD2E        = 32'd4;
      #1;
      chk("add after flush", 64'(bus.ALUResultE), 64'd7);
      chk("add after flush stall", 64'(bus.StallEX), 64'd0);
      bus.validE = 1'b0;
      m_op("div after flush", 3'b100, 32'hFFFF_FF00, 32'd16);

      // reset in the middle of a divide
      @(negedge clk);
      bus.ForwardAE = 2'd0;
      bus.ForwardBE = 2'd0;
      bus.RD1E      = 32'd50;
      bus.RD2E      = 32'd5;
      bus.funct3E   = 3'b101;
      bus.validE    = 1'b1;
      bus.MulDivE   = 1'b1;
      repeat (6) @(negedge clk);
      bus.validE  = 1'b0;
      bus.MulDivE = 1'b0;
      reset       = 1'b1;
      #1;
      chk("midbusy reset stall", 64'(bus.StallEX), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      m_op("divu 9/3 after reset", 3'b101, 32'd9, 32'd3);

      // randomized M operations
      for (int i = 0; i < 40; i++) begin
         logic [2:0] f3;
         logic [31:0] a, b;
         f3 = 3'($urandom_range(0, 7));
         a  = pick_op();
         b  = pick_op();
         m_op($sformatf("rand m%0d f3=%0d", i, f3), f3, a, b);
      end

      // randomized non-M operations
      for (int i = 0; i < 40; i++) begin
         alu_vec(i);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
